// File: rtl/vga_rect_draw_arbiter.sv
// rtl/vga_rect_draw_arbiter.sv - round-robin arbiter that walks one client rectangle per grant onto the vga_adapter pixel port
// Optional VGA_RECT_OUTLINE_EN: per-client rect_outline input, plot only border pixels.
module vga_rect_draw_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [9*NUM_REQ-1:0] rect_x0,
  input  logic [8*NUM_REQ-1:0] rect_y0,
  input  logic [9*NUM_REQ-1:0] rect_w,
  input  logic [8*NUM_REQ-1:0] rect_h,
  input  logic [3*NUM_REQ-1:0] rect_color,
`ifdef VGA_RECT_OUTLINE_EN
  input  logic [NUM_REQ-1:0]   rect_outline,
`endif
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [8:0]           x,
  output logic [7:0]           y,
  output logic [2:0]           color,
  output logic                 plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] SW = 10'(SCREEN_W);
  localparam logic [8:0] SH = 9'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d, k_q, k_d;
  logic [8:0]         x0_q, x0_d, w_q, w_d, dx_q, dx_d;
  logic [7:0]         y0_q, y0_d, h_q, h_d, dy_q, dy_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               busy_d, plot_d;
  logic [8:0]         x_d;
  logic [7:0]         y_d;
  logic [2:0]         color_d;
  logic [9:0]         sx;
  logic [8:0]         sy;
  logic               found, edge_ok;
  logic [IW-1:0]      pick, idx;
`ifdef VGA_RECT_OUTLINE_EN
  logic               ol_q, ol_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      k_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      x       <= '0;
      y       <= '0;
      color   <= '0;
      plot    <= 1'b0;
`ifdef VGA_RECT_OUTLINE_EN
      ol_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      k_q     <= k_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      x       <= x_d;
      y       <= y_d;
      color   <= color_d;
      plot    <= plot_d;
`ifdef VGA_RECT_OUTLINE_EN
      ol_q    <= ol_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    k_d     = k_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    color_d = color;
    grant_d = grant;
    done_d  = '0;
    found   = 1'b0;
    pick    = rr_q;
    idx     = '0;
`ifdef VGA_RECT_OUTLINE_EN
    ol_d    = ol_q;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        // Scan from the rr pointer so the most recently served client goes last.
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = IW'((int'(rr_q) + i) % NUM_REQ);
          if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          k_d           = pick;
          grant_d[pick] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        x0_d    = rect_x0[9*k_q +: 9];
        y0_d    = rect_y0[8*k_q +: 8];
        w_d     = rect_w[9*k_q +: 9];
        h_d     = rect_h[8*k_q +: 8];
        color_d = rect_color[3*k_q +: 3];
`ifdef VGA_RECT_OUTLINE_EN
        ol_d    = rect_outline[k_q];
`endif
        dx_d    = '0;
        dy_d    = '0;
        if (w_d == 9'd0 || h_d == 8'd0) begin
          state_d     = DONE;
          done_d[k_q] = 1'b1;
        end else begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (dx_q == w_q - 9'd1 && dy_q == h_q - 8'd1) begin
          state_d     = DONE;
          done_d[k_q] = 1'b1;
        end else if (dx_q == w_q - 9'd1) begin
          dx_d = '0;
          dy_d = dy_q + 8'd1;
        end else begin
          dx_d = dx_q + 9'd1;
        end
      end
      DONE: begin
        grant_d = '0;
        rr_d    = (k_q == IW'(NUM_REQ - 1)) ? '0 : k_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pixel registers are loaded with the coordinate that will be shown next cycle.
    sx = {1'b0, x0_d} + {1'b0, dx_d};
    sy = {1'b0, y0_d} + {1'b0, dy_d};
`ifdef VGA_RECT_OUTLINE_EN
    edge_ok = !ol_d || dx_d == 9'd0 || dx_d == w_d - 9'd1 ||
              dy_d == 8'd0 || dy_d == h_d - 8'd1;
`else
    edge_ok = 1'b1;
`endif
    x_d    = (state_d == DRAW) ? sx[8:0] : x;
    y_d    = (state_d == DRAW) ? sy[7:0] : y;
    plot_d = (state_d == DRAW) && (sx < SW) && (sy < SH) && edge_ok;
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_vga_rect_draw_arbiter.sv
// tb/tb_vga_rect_draw_arbiter.sv - scoreboard bench for vga_rect_draw_arbiter
module tb_vga_rect_draw_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] rect_x0 = '0;
  logic [8*N-1:0] rect_y0 = '0;
  logic [9*N-1:0] rect_w = '0;
  logic [8*N-1:0] rect_h = '0;
  logic [3*N-1:0] rect_color = '0;
  logic [N-1:0]   rect_outline = '0;
  logic [N-1:0]   grant, done;
  logic           busy, plot;
  logic [8:0]     x;
  logic [7:0]     y;
  logic [2:0]     color;

  int checks = 0;
  int failures = 0;
  int cyc;

  logic [19:0]  exp_pix[$];
  logic [N-1:0] exp_done[$];
  logic [N-1:0] exp_grant[$];
  logic [N-1:0] prev_grant = '0;
  logic [19:0]  pe;
  logic [N-1:0] ge;

  vga_rect_draw_arbiter #(.NUM_REQ(N), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color),
`ifdef VGA_RECT_OUTLINE_EN
    .rect_outline(rect_outline),
`endif
    .grant(grant), .done(done), .busy(busy),
    .x(x), .y(y), .color(color), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel, done pulse or new grant.
  always @(negedge clk) begin
    if (rst) begin
      if (plot) begin
        if (exp_pix.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_plot actual=(%0d,%0d) required=none", x, y);
        end else begin
          pe = exp_pix.pop_front();
          chk("pixel", {12'b0, x, y, color}, {12'b0, pe});
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=%0b required=none", done);
        end else begin
          ge = exp_done.pop_front();
          chk("done", 32'(done), 32'(ge));
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant actual=%0b required=none", grant);
        end else begin
          ge = exp_grant.pop_front();
          chk("grant", 32'(grant), 32'(ge));
        end
      end
    end
    prev_grant = grant;
  end

  task automatic set_client(input int k, input int x0, input int y0, input int w,
                            input int h, input int col, input bit ol);
    rect_x0[9*k +: 9]    = 9'(x0);
    rect_y0[8*k +: 8]    = 8'(y0);
    rect_w[9*k +: 9]     = 9'(w);
    rect_h[8*k +: 8]     = 8'(h);
    rect_color[3*k +: 3] = 3'(col);
    rect_outline[k]      = ol;
  endtask

  task automatic push_pix(input int px, input int py, input int col);
    exp_pix.push_back({9'(px), 8'(py), 3'(col)});
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int col);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        if (x0 + i < 320 && y0 + j < 240) push_pix(x0 + i, y0 + j, col);
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      n++;
      if (done[k]) return;
    end
    checks++; failures++;
    $display("FAIL timeout_done client=%0d actual=none required=pulse", k);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_color", 32'(color), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 2x2 filled rectangle for client 0.
    set_client(0, 10, 20, 2, 2, 3'b100, 0);
    push_pix(10, 20, 4); push_pix(11, 20, 4); push_pix(10, 21, 4); push_pix(11, 21, 4);
    exp_grant.push_back(3'b001); exp_done.push_back(3'b001);
    req[0] = 1'b1;
    wait_done(0, cyc);
    req[0] = 1'b0;
    chk("latency_2x2", 32'(cyc), 6);
    @(posedge clk); #1;
    chk("busy_fall", 32'(busy), 0);

    // Empty rectangle: grant for LOAD and DONE only.
    set_client(1, 0, 0, 0, 5, 6, 0);
    exp_grant.push_back(3'b010); exp_done.push_back(3'b010);
    req[1] = 1'b1;
    for (int t = 0; t < 20 && !grant[1]; t++) begin @(posedge clk); #1; end
    chk("empty_grant1", 32'(grant), 32'b010);
    chk("empty_nodone1", 32'(done), 0);
    @(posedge clk); #1;
    chk("empty_grant2", 32'(grant), 32'b010);
    chk("empty_done2", 32'(done), 32'b010);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("empty_grant_drop", 32'(grant), 0);
    chk("empty_busy", 32'(busy), 0);

    // Clipping at the bottom-right corner.
    set_client(0, 318, 239, 4, 2, 5, 0);
    push_pix(318, 239, 5); push_pix(319, 239, 5);
    exp_grant.push_back(3'b001); exp_done.push_back(3'b001);
    req[0] = 1'b1;
    wait_done(0, cyc);
    req[0] = 1'b0;
    chk("latency_clip", 32'(cyc), 10);
    @(posedge clk); #1;

    // Reset in the middle of a 10x10 draw, then restart from the origin.
    set_client(0, 5, 5, 10, 10, 2, 0);
    push_rect(5, 5, 10, 10, 2);
    exp_grant.push_back(3'b001);
    req[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_plot", 32'(plot), 0);
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    exp_pix.delete();
    push_rect(5, 5, 10, 10, 2);
    exp_grant.push_back(3'b001); exp_done.push_back(3'b001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_done(0, cyc);
    req[0] = 1'b0;
    chk("latency_restart", 32'(cyc), 102);

    // Round robin from a fresh pointer.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_client(k, 100 + k, 50, 1, 1, k + 1, 0);
      exp_grant.push_back(N'(1) << k);
      push_pix(100 + k, 50, k + 1);
      exp_done.push_back(N'(1) << k);
    end
    req = 3'b111;
    for (int k = 0; k < N; k++) begin
      wait_done(k, cyc);
      req[k] = 1'b0;
    end
    @(posedge clk); #1;
    exp_grant.push_back(3'b001); push_pix(100, 50, 1); exp_done.push_back(3'b001);
    exp_grant.push_back(3'b100); push_pix(102, 50, 3); exp_done.push_back(3'b100);
    req = 3'b101;
    wait_done(0, cyc);
    req[0] = 1'b0;
    wait_done(2, cyc);
    req[2] = 1'b0;
    @(posedge clk); #1;

`ifdef VGA_RECT_OUTLINE_EN
    set_client(0, 0, 0, 3, 3, 7, 1);
    push_pix(0, 0, 7); push_pix(1, 0, 7); push_pix(2, 0, 7);
    push_pix(0, 1, 7); push_pix(2, 1, 7);
    push_pix(0, 2, 7); push_pix(1, 2, 7); push_pix(2, 2, 7);
    exp_grant.push_back(3'b001); exp_done.push_back(3'b001);
    req[0] = 1'b1;
    wait_done(0, cyc);
    req[0] = 1'b0;
    chk("latency_outline", 32'(cyc), 11);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("pix_left", 32'(exp_pix.size()), 0);
    chk("done_left", 32'(exp_done.size()), 0);
    chk("grant_left", 32'(exp_grant.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
